// File: rtl/img_scale_pkg.sv
// ============================================================================
// Module   : img_scale_pkg
// Desc     : Mode encodings, FSM states and destination-size helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package img_scale_pkg;

  localparam logic [1:0] c_MODE_COPY = 2'b00;
  localparam logic [1:0] c_MODE_REPL = 2'b01;
  localparam logic [1:0] c_MODE_DECI = 2'b10;
  localparam logic [1:0] c_MODE_AVG  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Destination extent along one axis; used for both width and height.
  function automatic int dst_dim(input logic [1:0] mode, input int src_len);
    case (mode)
      c_MODE_COPY: return src_len;
      c_MODE_REPL: return 2 * src_len;
      default:     return src_len / 2;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/img_scale_addr_gen.sv
// ============================================================================
// Module   : img_scale_addr_gen
// Desc     : Destination raster counters, source row accumulator, addresses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module img_scale_addr_gen
  import img_scale_pkg::*;
#(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_advance,
  input  logic [1:0]        i_mode,
  input  logic [1:0]        i_sub,
  input  logic [ADDR_W-1:0] i_src_base,
  input  logic [ADDR_W-1:0] i_dst_base,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_last
);

  localparam int c_X_W = $clog2(2 * SRC_W);
  localparam int c_Y_W = $clog2(2 * SRC_H);
  localparam logic [ADDR_W-1:0] c_ROW  = ADDR_W'(SRC_W);
  localparam logic [ADDR_W-1:0] c_ROW2 = ADDR_W'(2 * SRC_W);

  logic [c_X_W-1:0]  r_dx, w_dx_max;
  logic [c_Y_W-1:0]  r_dy, w_dy_max;
  logic [ADDR_W-1:0] r_row, r_dst_idx, r_src_base, r_dst_base;
  logic [ADDR_W-1:0] w_row_step, w_sx, w_sub_row;

  always_comb begin
    w_dx_max   = c_X_W'(dst_dim(i_mode, SRC_W) - 1);
    w_dy_max   = c_Y_W'(dst_dim(i_mode, SRC_H) - 1);
    w_row_step = c_ROW2;
    w_sx       = ADDR_W'({r_dx, i_sub[0]});
    w_sub_row  = '0;
    case (i_mode)
      c_MODE_COPY: begin
        w_row_step = c_ROW;
        w_sx       = ADDR_W'(r_dx);
      end
      c_MODE_REPL: begin
        // Source row advances only when leaving an odd destination row.
        w_row_step = r_dy[0] ? c_ROW : '0;
        w_sx       = ADDR_W'(r_dx >> 1);
      end
      c_MODE_DECI: w_sx = ADDR_W'({r_dx, 1'b0});
      default:     w_sub_row = i_sub[1] ? c_ROW : '0;
    endcase
  end

  assign o_rd_addr = i_start ? i_src_base : (r_src_base + r_row + w_sub_row + w_sx);
  assign o_wr_addr = r_dst_base + r_dst_idx;
  assign o_last    = (r_dx == w_dx_max) && (r_dy == w_dy_max);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dx       <= '0;
      r_dy       <= '0;
      r_row      <= '0;
      r_dst_idx  <= '0;
      r_src_base <= '0;
      r_dst_base <= '0;
    end else if (i_start) begin
      r_dx       <= '0;
      r_dy       <= '0;
      r_row      <= '0;
      r_dst_idx  <= '0;
      r_src_base <= i_src_base;
      r_dst_base <= i_dst_base;
    end else if (i_advance) begin
      r_dst_idx <= r_dst_idx + 1'b1;
      if (r_dx == w_dx_max) begin
        r_dx  <= '0;
        r_dy  <= r_dy + 1'b1;
        r_row <= r_row + w_row_step;
      end else begin
        r_dx <= r_dx + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/img_scale_engine.sv
// ============================================================================
// Module   : img_scale_engine
// Desc     : Raster image scaler (copy/replicate/decimate/average) over a
//            synchronous frame memory. Macro SCALE_AVG_EN enables AVERAGE.
// Revision : 1.0
// ============================================================================
`default_nettype none

module img_scale_engine
  import img_scale_pkg::*;
#(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 2
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [1:0]        MODE,
  input  logic [ADDR_W-1:0] SRC_BASE,
  input  logic [ADDR_W-1:0] DST_BASE,
  output logic              BUSY,
  output logic              FLAG_DONE,
  output logic              FLAG_ERR,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [PIX_W-1:0]  RD_DATA,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [PIX_W-1:0]  WR_DATA
);

  state_t r_state, w_state_nxt;
  logic [1:0]        r_mode, r_sub, r_lat_cnt;
  logic              r_last;
  logic              w_lat_done, w_more_reads, w_mode_bad, w_last;
  logic              w_start_acc, w_advance, w_err;
  logic              w_busy, w_done, w_rd_en, w_wr_en;
  logic [ADDR_W-1:0] w_rd_addr, w_wr_addr;
  logic [PIX_W-1:0]  w_wr_pix;
  logic              r_busy, r_done, r_err, r_rd_en, r_wr_en;
  logic [ADDR_W-1:0] r_rd_addr, r_wr_addr;
  logic [PIX_W-1:0]  r_wr_data;

  img_scale_addr_gen #(
    .SRC_W  (SRC_W),
    .SRC_H  (SRC_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (CLOCK),
    .rst_n      (RESET_N),
    .i_start    (w_start_acc),
    .i_advance  (w_advance),
    .i_mode     (r_mode),
    .i_sub      (r_sub),
    .i_src_base (SRC_BASE),
    .i_dst_base (DST_BASE),
    .o_rd_addr  (w_rd_addr),
    .o_wr_addr  (w_wr_addr),
    .o_last     (w_last)
  );

  assign w_lat_done = (r_lat_cnt == 2'(RD_LAT - 1));
  // r_sub counts issued reads and wraps to 0 after the fourth AVERAGE read.
  assign w_more_reads = (r_mode == c_MODE_AVG) && (r_sub != 2'd0);

`ifdef SCALE_AVG_EN
  logic [PIX_W+1:0] r_acc, w_acc_sum;
  assign w_mode_bad = 1'b0;
  assign w_acc_sum  = r_acc + {2'b00, RD_DATA};
  assign w_wr_pix   = (r_mode == c_MODE_AVG) ? w_acc_sum[PIX_W+1:2] : RD_DATA;

  always_ff @(posedge CLOCK) begin
    if (!RESET_N)
      r_acc <= '0;
    else if ((r_state == S_WAIT) && w_lat_done)
      r_acc <= w_advance ? '0 : w_acc_sum;
  end
`else
  assign w_mode_bad = (MODE == c_MODE_AVG);
  assign w_wr_pix   = RD_DATA;
`endif

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (START && !w_mode_bad) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_WAIT;
      S_WAIT:  if (w_lat_done) w_state_nxt = w_more_reads ? S_READ : S_WRITE;
      S_WRITE: w_state_nxt = r_last ? S_DONE : S_READ;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registers line up with it.
  always_comb begin
    w_start_acc = (r_state == S_IDLE) && (w_state_nxt == S_READ);
    w_err       = (r_state == S_IDLE) && START && w_mode_bad;
    w_advance   = (r_state == S_WAIT) && (w_state_nxt == S_WRITE);
    w_busy      = (w_state_nxt == S_READ) || (w_state_nxt == S_WAIT) ||
                  (w_state_nxt == S_WRITE);
    w_done      = (w_state_nxt == S_DONE);
    w_rd_en     = (w_state_nxt == S_READ);
    w_wr_en     = (w_state_nxt == S_WRITE);
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      r_mode    <= '0;
      r_sub     <= '0;
      r_lat_cnt <= '0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_err     <= w_err;
      r_rd_en   <= w_rd_en;
      r_wr_en   <= w_wr_en;
      r_lat_cnt <= (r_state == S_WAIT) ? r_lat_cnt + 2'd1 : 2'd0;
      if (w_start_acc) r_mode <= MODE;
      if (w_rd_en) begin
        r_rd_addr <= w_rd_addr;
        r_sub     <= r_sub + 2'd1;
      end else if (w_advance) begin
        r_sub <= 2'd0;
      end
      if (w_advance) begin
        r_wr_addr <= w_wr_addr;
        r_wr_data <= w_wr_pix;
        r_last    <= w_last;
      end
    end
  end

  assign BUSY      = r_busy;
  assign FLAG_DONE = r_done;
  assign FLAG_ERR  = r_err;
  assign RD_EN     = r_rd_en;
  assign RD_ADDR   = r_rd_addr;
  assign WR_EN     = r_wr_en;
  assign WR_ADDR   = r_wr_addr;
  assign WR_DATA   = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_img_scale_engine.sv
// ============================================================================
// Module   : tb_img_scale_engine
// Desc     : Scoreboard bench for img_scale_engine with a memory model and a
//            frame-level reference model. Honours SCALE_AVG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_img_scale_engine;

  localparam int SW = 4;
  localparam int SH = 4;
  localparam int PW = 8;
  localparam int AW = 8;
  localparam int RL = 2;

  logic          clk_100 = 1'b0;
  logic          rst_n, start;
  logic [1:0]    mode;
  logic [AW-1:0] src_base, dst_base, rd_addr, wr_addr;
  logic          busy, flag_done, flag_err, rd_en, wr_en;
  logic [PW-1:0] rd_data, wr_data;

  always #5 clk_100 = ~clk_100;

  img_scale_engine #(
    .SRC_W (SW), .SRC_H (SH), .PIX_W (PW), .ADDR_W (AW), .RD_LAT (RL)
  ) dut (
    .CLOCK     (clk_100),
    .RESET_N   (rst_n),
    .START     (start),
    .MODE      (mode),
    .SRC_BASE  (src_base),
    .DST_BASE  (dst_base),
    .BUSY      (busy),
    .FLAG_DONE (flag_done),
    .FLAG_ERR  (flag_err),
    .RD_EN     (rd_en),
    .RD_ADDR   (rd_addr),
    .RD_DATA   (rd_data),
    .WR_EN     (wr_en),
    .WR_ADDR   (wr_addr),
    .WR_DATA   (wr_data)
  );

  // Synchronous memory: data for a read appears RL cycles later.
  logic [7:0] mem [256];
  logic [7:0] rd_pipe [RL];
  logic       ld_en;
  logic [7:0] ld_addr, ld_data;

  always @(posedge clk_100) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (ld_en) mem[ld_addr] <= ld_data;
    rd_pipe[0] <= mem[rd_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rd_data = rd_pipe[RL-1];

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;
  int n_reads  = 0;

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  always @(negedge clk_100) begin : monitor
    wr_t e;
    if (rd_en) n_reads++;
    if (rd_en || wr_en) chk("rd_wr_exclusive", 64'(rd_en & wr_en), 64'd0);
    if (wr_en) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %0d, none expected", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.a));
        chk("wr_data", 64'(wr_data), 64'(e.d));
      end
    end
  end

  // Reference model: frame-level arithmetic over the current memory image.
  function automatic int src_px(input logic [7:0] sb, input int x, input int y);
    return int'(mem[8'(int'(sb) + y * SW + x)]);
  endfunction

  function automatic int expect_op(input int md, input logic [7:0] sb, input logic [7:0] db);
    int dw, dh, v, idx;
    wr_t e;
    idx = 0;
    case (md)
      0:       begin dw = SW;     dh = SH;     end
      1:       begin dw = 2 * SW; dh = 2 * SH; end
      default: begin dw = SW / 2; dh = SH / 2; end
    endcase
    for (int dy = 0; dy < dh; dy++) begin
      for (int dx = 0; dx < dw; dx++) begin
        case (md)
          0:       v = src_px(sb, dx, dy);
          1:       v = src_px(sb, dx / 2, dy / 2);
          2:       v = src_px(sb, 2 * dx, 2 * dy);
          default: v = (src_px(sb, 2*dx, 2*dy) + src_px(sb, 2*dx+1, 2*dy) +
                        src_px(sb, 2*dx, 2*dy+1) + src_px(sb, 2*dx+1, 2*dy+1)) / 4;
        endcase
        e.a = 8'(int'(db) + idx);
        e.d = 8'(v);
        exp_q.push_back(e);
        idx++;
      end
    end
    return idx;
  endfunction

  // kind 0: value = address, 1: all 0xFF, 2: random
  task automatic load_src(input logic [7:0] sb, input int kind);
    for (int i = 0; i < SW * SH; i++) begin
      ld_en   = 1'b1;
      ld_addr = sb + 8'(i);
      ld_data = (kind == 0) ? ld_addr : (kind == 1) ? 8'hFF : 8'($urandom);
      @(posedge clk_100); #1;
    end
    ld_en = 1'b0;
  endtask

  task automatic run_op(input int md, input logic [7:0] sb, input logic [7:0] db, input bit poke);
    int npix, cpp, cyc, w0;
    bit seen;
    npix = expect_op(md, sb, db);
    cpp  = (md == 3) ? 4 * (RL + 1) + 1 : RL + 2;
    w0   = n_writes;
    mode = 2'(md); src_base = sb; dst_base = db; start = 1'b1;
    cyc  = 1;  // the START cycle itself
    seen = 1'b0;
    while (!seen && cyc < 5000) begin
      @(posedge clk_100); #1;
      cyc++;
      start = 1'b0;
      if (poke && cyc == 10) begin
        start = 1'b1; mode = ~mode; src_base = sb + 8'd1;
      end
      if (cyc == 2) chk("busy_raised", 64'(busy), 64'd1);
      if (flag_done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("latency_start_to_done", 64'(cyc), 64'(1 + npix * cpp + 1));
    chk("busy_low_in_done", 64'(busy), 64'd0);
    @(posedge clk_100); #1;
    chk("done_single_cycle", 64'(flag_done), 64'd0);
    chk("write_count", 64'(n_writes - w0), 64'(npix));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, cnt, r0;
    int rep_row[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int dec_exp[4] = '{0, 2, 8, 10};
    int avg_exp[4] = '{2, 4, 10, 12};
    int md;
    logic [7:0] sb, db;

    rst_n = 1'b0; start = 1'b0; mode = '0; src_base = '0; dst_base = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk_100);
    #1;
    chk("reset_state", 64'({busy, flag_done, flag_err, rd_en, wr_en, rd_addr, wr_addr, wr_data}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk_100); #1;

    load_src(8'd0, 0);
    run_op(0, 8'd0, 8'd64, 1'b0);

    run_op(1, 8'd0, 8'd64, 1'b0);
    for (int k = 0; k < 8; k++) begin
      chk("repl_row0", 64'(mem[64 + k]), 64'(rep_row[k]));
      chk("repl_row1", 64'(mem[72 + k]), 64'(rep_row[k]));
    end

    // START raised mid-operation must be ignored.
    run_op(2, 8'd0, 8'd64, 1'b1);
    for (int k = 0; k < 4; k++) chk("decimate_px", 64'(mem[64 + k]), 64'(dec_exp[k]));

`ifdef SCALE_AVG_EN
    run_op(3, 8'd0, 8'd64, 1'b0);
    for (int k = 0; k < 4; k++) chk("average_px", 64'(mem[64 + k]), 64'(avg_exp[k]));
    load_src(8'd0, 1);
    run_op(3, 8'd0, 8'd64, 1'b0);
    for (int k = 0; k < 4; k++) chk("average_ff", 64'(mem[64 + k]), 64'd255);
    load_src(8'd0, 0);
`else
    r0 = n_reads;
    mode = 2'b11; start = 1'b1;
    @(posedge clk_100); #1;
    start = 1'b0;
    chk("err_pulse", 64'(flag_err), 64'd1);
    chk("err_busy_low", 64'(busy), 64'd0);
    @(posedge clk_100); #1;
    chk("err_single_cycle", 64'(flag_err), 64'd0);
    chk("err_stays_idle", 64'(busy), 64'd0);
    repeat (5) @(posedge clk_100);
    #1;
    chk("err_no_reads", 64'(n_reads - r0), 64'd0);
`endif

    // Abort a COPY after five writes.
    w0 = n_writes;
    void'(expect_op(0, 8'd0, 8'd64));
    mode = 2'b00; src_base = 8'd0; dst_base = 8'd64; start = 1'b1;
    @(posedge clk_100); #1;
    start = 1'b0;
    cnt = 0;
    while ((n_writes - w0) < 5 && cnt < 500) begin
      @(posedge clk_100); #1;
      cnt++;
    end
    chk("abort_five_writes", 64'(n_writes - w0), 64'd5);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk_100); #1;
    chk("abort_outputs_zero", 64'({busy, flag_done, flag_err, rd_en, wr_en, rd_addr, wr_addr, wr_data}), 64'd0);
    @(posedge clk_100); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk_100);
    #1;
    chk("abort_no_more_writes", 64'(n_writes - w0), 64'd5);
    run_op(0, 8'd0, 8'd64, 1'b0);

    for (int t = 0; t < 8; t++) begin
`ifdef SCALE_AVG_EN
      md = int'($urandom_range(0, 3));
`else
      md = int'($urandom_range(0, 2));
`endif
      sb = 8'($urandom);
      db = sb + 8'd16 + 8'($urandom_range(0, 100));
      load_src(sb, 2);
      run_op(md, sb, db, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
